// File: rtl/sym_serializer.sv
// sym_serializer: splits each accepted byte into four 2-bit symbols.
// MSB_FIRST selects whether bits [7:6] or bits [1:0] go out first.
// Optional feature macro SYM_PARITY_EN adds a fifth symbol {1'b0, ^byte}
// after the data symbols (state PAR). The default build leaves it out.
// sym/first/sym_valid come straight from flops, so a stalled symbol
// holds without any extra logic.
module sym_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym,
  output logic       first,
  output logic       sym_valid,
  input  logic       sym_ready
);

`ifdef SYM_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t     state_q;
  logic [1:0] idx_q;
  logic [7:0] hold_q;
  logic [1:0] sym_q;
  logic       first_q;
  logic       vld_q;

  logic       last_xfer;
  logic       accept;

  // Pick symbol i of a byte in the configured bit order.
  function automatic logic [1:0] pick(input logic [7:0] d, input logic [1:0] i);
    logic [1:0] s;
    if (MSB_FIRST) begin
      case (i)
        2'd0:    s = d[7:6];
        2'd1:    s = d[5:4];
        2'd2:    s = d[3:2];
        default: s = d[1:0];
      endcase
    end else begin
      case (i)
        2'd0:    s = d[1:0];
        2'd1:    s = d[3:2];
        2'd2:    s = d[5:4];
        default: s = d[7:6];
      endcase
    end
    return s;
  endfunction

  // The final symbol of a byte is leaving this cycle, so a new byte can
  // load on the same edge with no bubble.
  always_comb begin
`ifdef SYM_PARITY_EN
    last_xfer = (state_q == PAR) && sym_ready;
`else
    last_xfer = (state_q == SHIFT) && (idx_q == 2'd3) && sym_ready;
`endif
  end

  assign in_ready  = reset || (state_q == IDLE) || last_xfer;
  assign accept    = in_valid && in_ready;

  assign sym       = sym_q;
  assign first     = first_q;
  assign sym_valid = vld_q;

  // Serializer FSM with registered symbol outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= 8'h00;
      sym_q   <= 2'b00;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
    end else if (accept) begin
      // accept is only possible in IDLE or on the last transfer, so a new
      // byte always restarts at index 0 regardless of the current state.
      state_q <= SHIFT;
      idx_q   <= 2'd0;
      hold_q  <= in_data;
      sym_q   <= pick(in_data, 2'd0);
      first_q <= 1'b1;
      vld_q   <= 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (sym_ready) begin
            if (idx_q != 2'd3) begin
              idx_q   <= idx_q + 2'd1;
              sym_q   <= pick(hold_q, idx_q + 2'd1);
              first_q <= 1'b0;
            end else begin
`ifdef SYM_PARITY_EN
              state_q <= PAR;
              sym_q   <= {1'b0, ^hold_q};
              first_q <= 1'b0;
`else
              state_q <= IDLE;
              sym_q   <= 2'b00;
              first_q <= 1'b0;
              vld_q   <= 1'b0;
`endif
            end
          end
        end
`ifdef SYM_PARITY_EN
        PAR: begin
          if (sym_ready) begin
            state_q <= IDLE;
            sym_q   <= 2'b00;
            first_q <= 1'b0;
            vld_q   <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sym_serializer.sv
// Directed bench for sym_serializer. Two instances share the stimulus:
// one MSB-first, one LSB-first. Expected symbols are hand-derived.
module tb_sym_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       sym_ready;

  logic       m_in_ready, m_first, m_sym_valid;
  logic [1:0] m_sym;
  logic       l_in_ready, l_first, l_sym_valid;
  logic [1:0] l_sym;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sym_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .sym(m_sym), .first(m_first),
    .sym_valid(m_sym_valid), .sym_ready(sym_ready)
  );

  sym_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .sym(l_sym), .first(l_first),
    .sym_valid(l_sym_valid), .sym_ready(sym_ready)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs (after inputs settle), then advance one clock.
  task automatic cyc(input string tag, input logic [1:0] em, input logic [1:0] el,
                     input logic ef, input logic ev, input logic er);
    #1;
    chk({tag, ".msb_sym"}, m_sym, em);
    chk({tag, ".lsb_sym"}, l_sym, el);
    chk({tag, ".first"},   {1'b0, m_first},     {1'b0, ef});
    chk({tag, ".lfirst"},  {1'b0, l_first},     {1'b0, ef});
    chk({tag, ".valid"},   {1'b0, m_sym_valid}, {1'b0, ev});
    chk({tag, ".lvalid"},  {1'b0, l_sym_valid}, {1'b0, ev});
    chk({tag, ".ready"},   {1'b0, m_in_ready},  {1'b0, er});
    chk({tag, ".lready"},  {1'b0, l_in_ready},  {1'b0, er});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB4;
    sym_ready = 1'b1;
    @(posedge clk); #1;
    // held in reset with in_valid high: nothing accepted, in_ready forced high
    cyc("rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    reset    = 1'b0;
    in_valid = 1'b0;
    cyc("idle0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

`ifdef SYM_PARITY_EN
    // 0x07: data 0,0,1,3 (lsb 3,1,0,0) then parity 1
    in_valid = 1'b1; in_data = 8'h07;
    cyc("p7acc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("p7s0", 2'd0, 2'd3, 1'b1, 1'b1, 1'b0);
    cyc("p7s1", 2'd0, 2'd1, 1'b0, 1'b1, 1'b0);
    cyc("p7s2", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("p7s3", 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("p7par", 2'd1, 2'd1, 1'b0, 1'b1, 1'b1);
    cyc("p7idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    // 0x03: parity symbol 0
    in_valid = 1'b1; in_data = 8'h03;
    cyc("p3acc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("p3s0", 2'd0, 2'd3, 1'b1, 1'b1, 1'b0);
    cyc("p3s1", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("p3s2", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("p3s3", 2'd3, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("p3par", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    cyc("p3idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
`else
    // 0xB4: msb 2,3,1,0  lsb 0,1,3,2
    in_valid = 1'b1; in_data = 8'hB4;
    cyc("b4acc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("b4s0", 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    cyc("b4s1", 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    cyc("b4s2", 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("b4s3", 2'd0, 2'd2, 1'b0, 1'b1, 1'b1);
    in_data = 8'h55;  // must be ignored, in_valid low
    cyc("b4idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc("ignore", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // back-to-back 0xFF then 0x00 with in_valid held high
    in_valid = 1'b1; in_data = 8'hFF;
    cyc("ffacc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_data = 8'h00;
    cyc("ffs0", 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    cyc("ffs1", 2'd3, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("ffs2", 2'd3, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("ffs3", 2'd3, 2'd3, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    cyc("00s0", 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    cyc("00s1", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("00s2", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc("00s3", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    cyc("00idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // 0xB4 with a 3-cycle stall at index 2
    in_valid = 1'b1; in_data = 8'hB4;
    cyc("stacc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("sts0", 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    cyc("sts1", 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    sym_ready = 1'b0;
    cyc("sthold0", 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("sthold1", 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("sthold2", 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    sym_ready = 1'b1;
    cyc("sts2", 2'd1, 2'd3, 1'b0, 1'b1, 1'b0);
    cyc("sts3", 2'd0, 2'd2, 1'b0, 1'b1, 1'b1);
    cyc("stidle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // reset after two symbols of 0xB4, then 0x5A: msb 1,1,2,2  lsb 2,2,1,1
    in_valid = 1'b1; in_data = 8'hB4;
    cyc("rmacc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("rms0", 2'd2, 2'd0, 1'b1, 1'b1, 1'b0);
    cyc("rms1", 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("rmrst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    cyc("rmidle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h5A;
    cyc("5aacc", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    cyc("5as0", 2'd1, 2'd2, 1'b1, 1'b1, 1'b0);
    cyc("5as1", 2'd1, 2'd2, 1'b0, 1'b1, 1'b0);
    cyc("5as2", 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    cyc("5as3", 2'd2, 2'd1, 1'b0, 1'b1, 1'b1);
    cyc("5aidle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
